// File: rtl/trap_controller.sv
// Trap/interrupt sequencer: accepts an exception, interrupt or MRET in IDLE,
// then walks FLUSH -> WRITE -> REDIRECT, driving CSR updates and the fetch redirect.
module trap_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid_i,
    input  logic [3:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    input  logic        mret_i,
    input  logic        irq_ext_i,
    input  logic        irq_sw_i,
    input  logic        irq_timer_i,
    input  logic        instruction_finished_i,
    input  logic [31:0] irq_pc_i,
    input  logic        mstatus_mie_i,
    input  logic        mstatus_mpie_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        busy_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic        trap_wr_en_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mtval_o,
    output logic        mstatus_wr_en_o,
    output logic        mstatus_mie_o,
    output logic        mstatus_mpie_o,
    output logic [31:0] mip_o
);

    typedef enum logic [1:0] {IDLE, FLUSH, WRITE, REDIRECT} state_t;

    state_t      state, state_n;
    logic        is_mret_q, is_irq_q, mie_at_accept_q;
    logic [3:0]  code_q;

    logic        irq_gate, ext_en, sw_en, tmr_en, irq_any;
    logic [3:0]  irq_code;
    logic        take_exc, take_irq, take_mret;
    logic [31:0] tvec_base, target;
    logic        unused_ok;

    assign unused_ok = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0], mepc_i[0]};

    assign irq_gate  = mstatus_mie_i & instruction_finished_i;
    assign ext_en    = irq_gate & irq_ext_i   & mie_i[11];
    assign sw_en     = irq_gate & irq_sw_i    & mie_i[3];
    assign tmr_en    = irq_gate & irq_timer_i & mie_i[7];
    assign irq_any   = ext_en | sw_en | tmr_en;
    assign irq_code  = ext_en ? 4'd11 : (sw_en ? 4'd3 : 4'd7);

    assign take_exc  = exc_valid_i;
    assign take_irq  = !exc_valid_i & irq_any;
    assign take_mret = !exc_valid_i & !irq_any & mret_i;

    // Vectored mode only offsets interrupts; exceptions always land on the base.
    assign tvec_base = {mtvec_i[31:2], 2'b00};
    always_comb begin
        target = tvec_base;
        if (is_mret_q)
            target = {mepc_i[31:1], 1'b0};
        else if (is_irq_q && mtvec_i[1:0] == 2'b01)
            target = tvec_base + {26'b0, code_q, 2'b00};
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (take_exc || take_irq || take_mret) state_n = FLUSH;
            FLUSH:    state_n = WRITE;
            WRITE:    state_n = REDIRECT;
            REDIRECT: if (redirect_ready_i) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Event capture; MRET leaves the trap CSR image untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_mret_q       <= 1'b0;
            is_irq_q        <= 1'b0;
            mie_at_accept_q <= 1'b0;
            code_q          <= 4'd0;
            mepc_o          <= 32'd0;
            mcause_o        <= 32'd0;
            mtval_o         <= 32'd0;
        end else if (state == IDLE) begin
            if (take_exc) begin
                is_mret_q       <= 1'b0;
                is_irq_q        <= 1'b0;
                mie_at_accept_q <= mstatus_mie_i;
                code_q          <= exc_cause_i;
                mepc_o          <= exc_pc_i;
                mcause_o        <= {28'd0, exc_cause_i};
                mtval_o         <= exc_tval_i;
            end else if (take_irq) begin
                is_mret_q       <= 1'b0;
                is_irq_q        <= 1'b1;
                mie_at_accept_q <= mstatus_mie_i;
                code_q          <= irq_code;
                mepc_o          <= irq_pc_i;
                mcause_o        <= {1'b1, 27'd0, irq_code};
                mtval_o         <= 32'd0;
            end else if (take_mret) begin
                is_mret_q       <= 1'b1;
                is_irq_q        <= 1'b0;
            end
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_o           <= 1'b0;
            flush_o          <= 1'b0;
            trap_wr_en_o     <= 1'b0;
            mstatus_wr_en_o  <= 1'b0;
            mstatus_mie_o    <= 1'b0;
            mstatus_mpie_o   <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= 32'd0;
            mip_o            <= 32'd0;
        end else begin
            busy_o           <= (state_n != IDLE);
            flush_o          <= (state_n == FLUSH);
            trap_wr_en_o     <= (state_n == WRITE) && !is_mret_q;
            mstatus_wr_en_o  <= (state_n == WRITE);
            mstatus_mie_o    <= (state_n == WRITE) && is_mret_q && mstatus_mpie_i;
            mstatus_mpie_o   <= (state_n == WRITE) && (is_mret_q || mie_at_accept_q);
            redirect_valid_o <= (state_n == REDIRECT);
            if (state == WRITE)
                redirect_pc_o <= target;
            else if (state_n == IDLE)
                redirect_pc_o <= 32'd0;
            mip_o <= {20'd0, irq_ext_i, 3'd0, irq_timer_i, 3'd0, irq_sw_i, 3'd0};
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: one task per scenario, hand-computed expectations.
module tb_trap_controller;

    logic        clk, rst;
    logic        exc_valid_i, mret_i, irq_ext_i, irq_sw_i, irq_timer_i, instruction_finished_i;
    logic [3:0]  exc_cause_i;
    logic [31:0] exc_pc_i, exc_tval_i, irq_pc_i, mie_i, mtvec_i, mepc_i;
    logic        mstatus_mie_i, mstatus_mpie_i, redirect_ready_i;
    logic        busy_o, flush_o, redirect_valid_o, trap_wr_en_o, mstatus_wr_en_o;
    logic        mstatus_mie_o, mstatus_mpie_o;
    logic [31:0] redirect_pc_o, mepc_o, mcause_o, mtval_o, mip_o;

    int vecs = 0;
    int errs = 0;

    trap_controller dut (
        .clk(clk), .rst(rst),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
        .mret_i(mret_i), .irq_ext_i(irq_ext_i), .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i),
        .instruction_finished_i(instruction_finished_i), .irq_pc_i(irq_pc_i),
        .mstatus_mie_i(mstatus_mie_i), .mstatus_mpie_i(mstatus_mpie_i), .mie_i(mie_i),
        .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .busy_o(busy_o), .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i),
        .trap_wr_en_o(trap_wr_en_o), .mepc_o(mepc_o), .mcause_o(mcause_o), .mtval_o(mtval_o),
        .mstatus_wr_en_o(mstatus_wr_en_o), .mstatus_mie_o(mstatus_mie_o),
        .mstatus_mpie_o(mstatus_mpie_o), .mip_o(mip_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        exc_valid_i = 0; exc_cause_i = 0; exc_pc_i = 0; exc_tval_i = 0;
        mret_i = 0; irq_ext_i = 0; irq_sw_i = 0; irq_timer_i = 0;
        instruction_finished_i = 0; irq_pc_i = 0;
        mstatus_mie_i = 0; mstatus_mpie_i = 0; mie_i = 0; mtvec_i = 0; mepc_i = 0;
        redirect_ready_i = 1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1;
        irq_ext_i = 1; exc_valid_i = 1;
        tick(); tick();
        vecs++;
        if ({busy_o, flush_o, redirect_valid_o, redirect_pc_o, trap_wr_en_o, mepc_o, mcause_o, mtval_o,
             mstatus_wr_en_o, mstatus_mie_o, mstatus_mpie_o, mip_o} !== '0) begin
            errs++; $display("FAIL reset_outputs got busy=%b flush=%b rv=%b mip=%h want all 0",
                             busy_o, flush_o, redirect_valid_o, mip_o);
        end
        clear_inputs();
    endtask

    // Released reset and an exception share one edge: accepted immediately.
    task automatic test_exception;
        exc_valid_i = 1; exc_cause_i = 2; exc_pc_i = 32'h100; exc_tval_i = 32'hDEAD;
        mtvec_i = 32'h800; mstatus_mie_i = 1; rst = 0;
        tick(); exc_valid_i = 0;
        vecs++;
        if ({flush_o, busy_o, trap_wr_en_o, redirect_valid_o} !== 4'b1100) begin
            errs++; $display("FAIL exc_flush got %b want 1100", {flush_o, busy_o, trap_wr_en_o, redirect_valid_o});
        end
        tick();
        vecs++;
        if ({flush_o, busy_o, trap_wr_en_o, mstatus_wr_en_o, mstatus_mie_o, mstatus_mpie_o} !== 6'b011101) begin
            errs++; $display("FAIL exc_write_ctl got %b want 011101",
                             {flush_o, busy_o, trap_wr_en_o, mstatus_wr_en_o, mstatus_mie_o, mstatus_mpie_o});
        end
        vecs++;
        if ({mepc_o, mcause_o, mtval_o} !== {32'h100, 32'h2, 32'hDEAD}) begin
            errs++; $display("FAIL exc_write_csr got %h %h %h want 100 2 dead", mepc_o, mcause_o, mtval_o);
        end
        tick();
        vecs++;
        if ({redirect_valid_o, busy_o, trap_wr_en_o, mstatus_wr_en_o, redirect_pc_o} !== {4'b1100, 32'h800}) begin
            errs++; $display("FAIL exc_redirect got rv=%b busy=%b tw=%b sw=%b pc=%h want 1 1 0 0 800",
                             redirect_valid_o, busy_o, trap_wr_en_o, mstatus_wr_en_o, redirect_pc_o);
        end
        tick();
        vecs++;
        if ({redirect_valid_o, busy_o} !== 2'b00) begin
            errs++; $display("FAIL exc_idle got %b want 00", {redirect_valid_o, busy_o});
        end
        clear_inputs();
    endtask

    task automatic test_vectored_irq;
        mtvec_i = 32'h801; mie_i = 32'h80; mstatus_mie_i = 1; irq_timer_i = 1;
        instruction_finished_i = 1; irq_pc_i = 32'h200;
        tick();
        vecs++;
        if ({flush_o, mip_o} !== {1'b1, 32'h80}) begin
            errs++; $display("FAIL irq_accept got flush=%b mip=%h want 1 80", flush_o, mip_o);
        end
        irq_timer_i = 0; instruction_finished_i = 0;
        tick();
        vecs++;
        if ({trap_wr_en_o, mepc_o, mcause_o, mtval_o} !== {1'b1, 32'h200, 32'h80000007, 32'h0}) begin
            errs++; $display("FAIL irq_write got tw=%b %h %h %h want 1 200 80000007 0",
                             trap_wr_en_o, mepc_o, mcause_o, mtval_o);
        end
        tick();
        vecs++;
        if ({redirect_valid_o, redirect_pc_o} !== {1'b1, 32'h81C}) begin
            errs++; $display("FAIL irq_vector_pc got %b %h want 1 81c", redirect_valid_o, redirect_pc_o);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_priority;
        exc_valid_i = 1; exc_cause_i = 5; exc_pc_i = 32'h300; exc_tval_i = 32'h55;
        irq_ext_i = 1; mie_i = 32'h800; mstatus_mie_i = 1; instruction_finished_i = 1;
        irq_pc_i = 32'h444; mret_i = 1; mtvec_i = 32'h801;
        tick();
        exc_valid_i = 0; irq_ext_i = 0; mret_i = 0;
        tick();
        vecs++;
        if ({trap_wr_en_o, mepc_o, mcause_o, mtval_o} !== {1'b1, 32'h300, 32'h5, 32'h55}) begin
            errs++; $display("FAIL prio_csr got tw=%b %h %h %h want 1 300 5 55",
                             trap_wr_en_o, mepc_o, mcause_o, mtval_o);
        end
        tick();
        vecs++;
        if (redirect_pc_o !== 32'h800) begin
            errs++; $display("FAIL prio_exc_base got %h want 800", redirect_pc_o);
        end
        tick(); tick();
        vecs++;
        if ({busy_o, flush_o} !== 2'b00) begin
            errs++; $display("FAIL prio_dropped got %b want 00", {busy_o, flush_o});
        end
        clear_inputs();
    endtask

    task automatic test_mret;
        mret_i = 1; mepc_i = 32'h303; mstatus_mpie_i = 1; mstatus_mie_i = 0; mtvec_i = 32'h900;
        tick(); mret_i = 0;
        vecs++;
        if ({flush_o, busy_o} !== 2'b11) begin
            errs++; $display("FAIL mret_flush got %b want 11", {flush_o, busy_o});
        end
        tick();
        vecs++;
        if ({trap_wr_en_o, mstatus_wr_en_o, mstatus_mie_o, mstatus_mpie_o, mepc_o} !== {4'b0111, 32'h300}) begin
            errs++; $display("FAIL mret_write got %b mepc=%h want 0111 300",
                             {trap_wr_en_o, mstatus_wr_en_o, mstatus_mie_o, mstatus_mpie_o}, mepc_o);
        end
        tick();
        vecs++;
        if ({redirect_valid_o, redirect_pc_o} !== {1'b1, 32'h302}) begin
            errs++; $display("FAIL mret_pc got %b %h want 1 302", redirect_valid_o, redirect_pc_o);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_redirect_stall;
        redirect_ready_i = 0;
        exc_valid_i = 1; exc_cause_i = 1; exc_pc_i = 32'h400; mtvec_i = 32'h900; mstatus_mie_i = 1;
        tick(); exc_valid_i = 0;
        tick(); tick();
        exc_valid_i = 1; exc_cause_i = 7; exc_pc_i = 32'h999;
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if ({redirect_valid_o, busy_o, flush_o, redirect_pc_o} !== {3'b110, 32'h900}) begin
                errs++; $display("FAIL stall_hold[%0d] got rv=%b busy=%b flush=%b pc=%h want 1 1 0 900",
                                 i, redirect_valid_o, busy_o, flush_o, redirect_pc_o);
            end
            tick();
        end
        exc_valid_i = 0; redirect_ready_i = 1;
        tick();
        vecs++;
        if ({redirect_valid_o, busy_o} !== 2'b00) begin
            errs++; $display("FAIL stall_release got %b want 00", {redirect_valid_o, busy_o});
        end
        tick();
        vecs++;
        if ({busy_o, flush_o, mepc_o} !== {2'b00, 32'h400}) begin
            errs++; $display("FAIL stall_not_queued got busy=%b flush=%b mepc=%h want 0 0 400",
                             busy_o, flush_o, mepc_o);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid;
        exc_valid_i = 1; exc_cause_i = 3; exc_pc_i = 32'h500; mtvec_i = 32'hA00; mstatus_mie_i = 1;
        tick(); exc_valid_i = 0;
        tick();
        vecs++;
        if (trap_wr_en_o !== 1'b1) begin
            errs++; $display("FAIL rstmid_in_write got %b want 1", trap_wr_en_o);
        end
        #2 rst = 1;
        #1;
        vecs++;
        if ({busy_o, flush_o, redirect_valid_o, redirect_pc_o, trap_wr_en_o, mepc_o, mcause_o, mtval_o,
             mstatus_wr_en_o, mstatus_mie_o, mstatus_mpie_o, mip_o} !== '0) begin
            errs++; $display("FAIL rstmid_outputs got busy=%b tw=%b sw=%b mepc=%h want all 0",
                             busy_o, trap_wr_en_o, mstatus_wr_en_o, mepc_o);
        end
        tick();
        clear_inputs();
        rst = 0; mstatus_mie_i = 0; irq_ext_i = 1; mie_i = 32'h888; instruction_finished_i = 1;
        tick();
        vecs++;
        if ({busy_o, flush_o, mip_o} !== {2'b00, 32'h800}) begin
            errs++; $display("FAIL masked_global got busy=%b flush=%b mip=%h want 0 0 800", busy_o, flush_o, mip_o);
        end
        mstatus_mie_i = 1; mie_i = 32'h0; irq_sw_i = 1;
        tick(); tick();
        vecs++;
        if ({busy_o, flush_o, mip_o} !== {2'b00, 32'h808}) begin
            errs++; $display("FAIL masked_mie got busy=%b flush=%b mip=%h want 0 0 808", busy_o, flush_o, mip_o);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_vectored_irq();
        test_priority();
        test_mret();
        test_redirect_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
